// File: rtl/brnch_fetch_sequencer.sv
// Fetch-side sequencer for the correlating branch predictor: PC, IF/ID register and next-PC selection.
// Optional FETCH_PERF_CNT_EN adds saturating branch, mispredict and stall-cycle counters.
module brnch_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] branch_fetched_cnt,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] stall_cycle_cnt,
`endif
  input  logic [31:0] instr_mem_rdata,
  input  logic        br_prediction,
  input  logic        flush,
  input  logic        branch_hazard_stall,
  input  logic        jump_detected,
  input  logic        load_use_stall,
  output logic [31:0] pc_IF,
  output logic [5:0]  opcode_for_brnch_instr_detect_IF,
  output logic [4:0]  branch_addr_lw_5b,
  output logic [5:0]  opcode_for_brnch_instr_detect_ID,
  output logic [4:0]  IFID_reg_rs,
  output logic [4:0]  IFID_reg_rt,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc_plus4,
  output logic        IFID_valid,
  output logic        IFID_pred_taken
);

  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        ifid_pred_q, ifid_pred_d;

  logic        stall;
  logic        in_boot;
  logic [5:0]  opcode_if;
  logic [31:0] pc4, br_tgt, j_tgt, rec;
  logic        flush_qual;

  assign stall = branch_hazard_stall | load_use_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = stall ? STALL : RUN;
      STALL:   state_d = stall ? STALL : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    in_boot   = (state_q == BOOT);
    opcode_if = in_boot ? '0 : instr_mem_rdata[31:26];
  end

  assign pc4        = pc_q + 32'd4;
  assign br_tgt     = pc4 + {{14{instr_mem_rdata[15]}}, instr_mem_rdata[15:0], 2'b00};
  assign j_tgt      = {pc4[31:28], instr_mem_rdata[25:0], 2'b00};
  assign rec        = ifid_pred_q ? ifid_pc_plus4_q
                    : ifid_pc_plus4_q + {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
  assign flush_qual = flush & ifid_valid_q & (ifid_instr_q[31:26] == OP_BEQ);

  // Stall outranks flush so a mispredict raised during a stall is kept until release.
  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_pred_d     = ifid_pred_q;
    if (in_boot) begin
      ifid_instr_d    = '0;
      ifid_pc_plus4_d = '0;
      ifid_valid_d    = 1'b0;
      ifid_pred_d     = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (flush_qual) begin
      pc_d            = rec;
      ifid_instr_d    = '0;
      ifid_pc_plus4_d = '0;
      ifid_valid_d    = 1'b0;
      ifid_pred_d     = 1'b0;
    end else begin
      ifid_instr_d    = instr_mem_rdata;
      ifid_pc_plus4_d = pc4;
      ifid_valid_d    = 1'b1;
      if (jump_detected) begin
        pc_d        = j_tgt;
        ifid_pred_d = 1'b0;
      end else if (br_prediction && (opcode_if == OP_BEQ)) begin
        pc_d        = br_tgt;
        ifid_pred_d = 1'b1;
      end else begin
        pc_d        = pc4;
        ifid_pred_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= RESET_VECTOR;
      ifid_instr_q    <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      ifid_pred_q     <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pred_q     <= ifid_pred_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;
  logic        fetch_wr, take_flush;

  assign take_flush = !in_boot && !stall && flush_qual;
  assign fetch_wr   = !in_boot && !stall && !flush_qual;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    st_cnt_d = st_cnt_q;
    if (fetch_wr && (opcode_if == OP_BEQ) && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 32'd1;
    if (take_flush && (mp_cnt_q != '1))                         mp_cnt_d = mp_cnt_q + 32'd1;
    if ((state_q == STALL) && (st_cnt_q != '1))                 st_cnt_d = st_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign branch_fetched_cnt = br_cnt_q;
  assign mispredict_cnt     = mp_cnt_q;
  assign stall_cycle_cnt    = st_cnt_q;
`endif

  assign pc_IF                            = pc_q;
  assign opcode_for_brnch_instr_detect_IF = opcode_if;
  assign branch_addr_lw_5b                = pc_q[6:2];
  assign opcode_for_brnch_instr_detect_ID = ifid_instr_q[31:26];
  assign IFID_reg_rs                      = ifid_instr_q[25:21];
  assign IFID_reg_rt                      = ifid_instr_q[20:16];
  assign IFID_instr                       = ifid_instr_q;
  assign IFID_pc_plus4                    = ifid_pc_plus4_q;
  assign IFID_valid                       = ifid_valid_q;
  assign IFID_pred_taken                  = ifid_pred_q;

endmodule

// File: tb/tb_brnch_fetch_sequencer.sv
// Directed self-checking bench for brnch_fetch_sequencer (RESET_VECTOR = 0x100).
module tb_brnch_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_mem_rdata = '0;
  logic        br_prediction = 1'b0;
  logic        flush = 1'b0;
  logic        branch_hazard_stall = 1'b0;
  logic        jump_detected = 1'b0;
  logic        load_use_stall = 1'b0;
  logic [31:0] pc_IF;
  logic [5:0]  op_if, op_id;
  logic [4:0]  idx5, rs, rt;
  logic [31:0] IFID_instr, IFID_pc_plus4;
  logic        IFID_valid, IFID_pred_taken;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] ADDI    = 32'h2043_0005; // opcode 001000, rs 2, rt 3
  localparam logic [31:0] BEQ_P4  = 32'h1022_0004;
  localparam logic [31:0] BEQ_M2  = 32'h1022_FFFE;
  localparam logic [31:0] BEQ_NEG = 32'h1022_8000;

  brnch_fetch_sequencer #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .instr_mem_rdata(instr_mem_rdata),
    .br_prediction(br_prediction), .flush(flush),
    .branch_hazard_stall(branch_hazard_stall), .jump_detected(jump_detected),
    .load_use_stall(load_use_stall), .pc_IF(pc_IF),
    .opcode_for_brnch_instr_detect_IF(op_if), .branch_addr_lw_5b(idx5),
    .opcode_for_brnch_instr_detect_ID(op_id), .IFID_reg_rs(rs), .IFID_reg_rt(rt),
    .IFID_instr(IFID_instr), .IFID_pc_plus4(IFID_pc_plus4),
    .IFID_valid(IFID_valid), .IFID_pred_taken(IFID_pred_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    instr_mem_rdata = ADDI;
    #1;
    n_checks++; if (pc_IF !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_IF, 32'h100); end
    n_checks++; if (IFID_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", IFID_instr); end
    n_checks++; if (IFID_valid !== 1'b0 || IFID_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got v=%b p=%b expected 0 0", IFID_valid, IFID_pred_taken); end
    n_checks++; if (op_if !== 6'd0) begin n_fail++; $display("FAIL reset_op_if: got %h expected 0", op_if); end
    n_checks++; if ({op_id, rs, rt, idx5} !== 21'd0) begin n_fail++; $display("FAIL reset_id_fields: got %h expected 0", {op_id, rs, rt, idx5}); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_boot_fetch();
    #1;
    n_checks++; if (op_if !== 6'd0) begin n_fail++; $display("FAIL boot_op_if: got %h expected 0", op_if); end
    tick();
    n_checks++; if (pc_IF !== 32'h100 || IFID_valid !== 1'b0) begin n_fail++; $display("FAIL boot_hold: got pc=%h v=%b expected 100 0", pc_IF, IFID_valid); end
    n_checks++; if (op_if !== 6'h08) begin n_fail++; $display("FAIL run_op_if: got %h expected 08", op_if); end
    tick();
    n_checks++; if (pc_IF !== 32'h104 || IFID_valid !== 1'b1) begin n_fail++; $display("FAIL first_fetch: got pc=%h v=%b expected 104 1", pc_IF, IFID_valid); end
    n_checks++; if (IFID_instr !== ADDI || IFID_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL first_ifid: got %h/%h expected %h/104", IFID_instr, IFID_pc_plus4, ADDI); end
    n_checks++; if (op_id !== 6'h08 || rs !== 5'd2 || rt !== 5'd3) begin n_fail++; $display("FAIL id_fields: got op=%h rs=%0d rt=%0d expected 08 2 3", op_id, rs, rt); end
    tick();
    n_checks++; if (pc_IF !== 32'h108) begin n_fail++; $display("FAIL seq_pc: got %h expected 108", pc_IF); end
  endtask

  task automatic test_jump();
    instr_mem_rdata = 32'h0800_0080;
    jump_detected   = 1'b1;
    tick();
    jump_detected = 1'b0;
    n_checks++; if (pc_IF !== 32'h200) begin n_fail++; $display("FAIL jump_pc: got %h expected 200", pc_IF); end
    n_checks++; if (IFID_valid !== 1'b1 || IFID_pred_taken !== 1'b0 || IFID_instr !== 32'h0800_0080) begin n_fail++; $display("FAIL jump_ifid: got v=%b p=%b i=%h expected 1 0 08000080", IFID_valid, IFID_pred_taken, IFID_instr); end
  endtask

  task automatic test_pred_taken();
    instr_mem_rdata = BEQ_P4;
    br_prediction   = 1'b1;
    tick();
    br_prediction = 1'b0;
    n_checks++; if (pc_IF !== 32'h214) begin n_fail++; $display("FAIL pred_pc: got %h expected 214", pc_IF); end
    n_checks++; if (IFID_pred_taken !== 1'b1 || IFID_pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL pred_ifid: got p=%b pc4=%h expected 1 204", IFID_pred_taken, IFID_pc_plus4); end
    n_checks++; if (idx5 !== 5'd5) begin n_fail++; $display("FAIL pred_idx: got %0d expected 5", idx5); end
  endtask

  task automatic test_mispredict_taken();
    instr_mem_rdata = ADDI;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (pc_IF !== 32'h204) begin n_fail++; $display("FAIL mp_taken_pc: got %h expected 204", pc_IF); end
    n_checks++; if (IFID_instr !== 32'h0 || IFID_valid !== 1'b0) begin n_fail++; $display("FAIL mp_taken_bubble: got i=%h v=%b expected 0 0", IFID_instr, IFID_valid); end
    tick();
    n_checks++; if (pc_IF !== 32'h208 || IFID_valid !== 1'b1) begin n_fail++; $display("FAIL mp_resume: got pc=%h v=%b expected 208 1", pc_IF, IFID_valid); end
    flush = 1'b1; // ID holds addi, so this flush must be ignored
    tick();
    flush = 1'b0;
    n_checks++; if (pc_IF !== 32'h20C || IFID_valid !== 1'b1) begin n_fail++; $display("FAIL unqual_flush: got pc=%h v=%b expected 20c 1", pc_IF, IFID_valid); end
  endtask

  task automatic test_mispredict_not_taken();
    instr_mem_rdata = 32'h0800_00C0;
    jump_detected   = 1'b1;
    tick();
    jump_detected   = 1'b0;
    instr_mem_rdata = BEQ_M2;
    tick();
    n_checks++; if (pc_IF !== 32'h304 || op_id !== 6'h04 || IFID_pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_fetch: got pc=%h op=%h p=%b expected 304 04 0", pc_IF, op_id, IFID_pred_taken); end
    instr_mem_rdata = ADDI;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (pc_IF !== 32'h2FC || IFID_valid !== 1'b0) begin n_fail++; $display("FAIL mp_nt_pc: got pc=%h v=%b expected 2fc 0", pc_IF, IFID_valid); end
  endtask

  task automatic test_stall_flush();
    instr_mem_rdata = BEQ_P4;
    br_prediction   = 1'b1;
    tick();
    br_prediction = 1'b0;
    n_checks++; if (pc_IF !== 32'h310) begin n_fail++; $display("FAIL stall_setup: got %h expected 310", pc_IF); end
    instr_mem_rdata     = ADDI;
    branch_hazard_stall = 1'b1;
    flush               = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc_IF !== 32'h310 || IFID_instr !== BEQ_P4 || IFID_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got pc=%h i=%h v=%b expected 310 %h 1", i, pc_IF, IFID_instr, IFID_valid, BEQ_P4); end
    end
    branch_hazard_stall = 1'b0;
    tick();
    flush = 1'b0;
    n_checks++; if (pc_IF !== 32'h300 || IFID_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_flush: got pc=%h v=%b expected 300 0", pc_IF, IFID_valid); end
    load_use_stall = 1'b1;
    tick();
    load_use_stall = 1'b0;
    n_checks++; if (pc_IF !== 32'h300 || IFID_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_hold: got pc=%h v=%b expected 300 0", pc_IF, IFID_valid); end
    tick();
    n_checks++; if (pc_IF !== 32'h304 || IFID_instr !== ADDI) begin n_fail++; $display("FAIL load_use_resume: got pc=%h i=%h expected 304 %h", pc_IF, IFID_instr, ADDI); end
  endtask

  task automatic test_wrap_jump();
    instr_mem_rdata = BEQ_NEG;
    br_prediction   = 1'b1;
    tick();
    br_prediction = 1'b0;
    n_checks++; if (pc_IF !== 32'hFFFE_0308) begin n_fail++; $display("FAIL wrap_pc: got %h expected fffe0308", pc_IF); end
    n_checks++; if (idx5 !== 5'd2) begin n_fail++; $display("FAIL wrap_idx: got %0d expected 2", idx5); end
    instr_mem_rdata = 32'h0800_0040;
    jump_detected   = 1'b1;
    tick();
    jump_detected = 1'b0;
    n_checks++; if (pc_IF !== 32'hF000_0100) begin n_fail++; $display("FAIL jump_hi_pc: got %h expected f0000100", pc_IF); end
    n_checks++; if (IFID_pc_plus4 !== 32'hFFFE_030C || IFID_valid !== 1'b1) begin n_fail++; $display("FAIL jump_hi_ifid: got pc4=%h v=%b expected fffe030c 1", IFID_pc_plus4, IFID_valid); end
  endtask

  task automatic test_reset_midop();
    instr_mem_rdata = BEQ_P4;
    flush = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pc_IF !== 32'h100 || IFID_valid !== 1'b0 || IFID_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL async_reset: got pc=%h v=%b pc4=%h expected 100 0 0", pc_IF, IFID_valid, IFID_pc_plus4); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (op_if !== 6'd0) begin n_fail++; $display("FAIL reboot_op_if: got %h expected 0", op_if); end
    tick();
    flush = 1'b0;
    n_checks++; if (pc_IF !== 32'h100 || IFID_valid !== 1'b0) begin n_fail++; $display("FAIL reboot_hold: got pc=%h v=%b expected 100 0", pc_IF, IFID_valid); end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_jump();
    test_pred_taken();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_stall_flush();
    test_wrap_jump();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
